// File: rtl/hc595_serial_loader.sv
// hc595_serial_loader: captures a byte on a start request, shifts it out on si/sck
// to a 74HC595-style stage, then issues one rck pulse so the byte reaches the storage outputs.
module hc595_serial_loader #(
  parameter int CLK_DIV   = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       si,
  output logic       sck,
  output logic       rck
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCK_LO = 3'd1,
    SCK_HI = 3'd2,
    LATCH  = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'd8;

  state_t     state_r;
  state_t     state_s;
  logic [7:0] shift_r;
  logic [7:0] shift_s;
  logic [3:0] bit_cnt_r;
  logic [3:0] bit_cnt_s;
  logic [7:0] div_r;
  logic [7:0] div_s;
  logic       busy_s;
  logic       done_s;
  logic       si_s;
  logic       sck_s;
  logic       rck_s;

  // The head bit is the next one to leave the shift register.
  function automatic logic head_bit(input logic [7:0] v);
    logic b;
    if (LSB_FIRST) begin
      b = v[0];
    end else begin
      b = v[7];
    end
    return b;
  endfunction

  function automatic logic [7:0] shift_toward_head(input logic [7:0] v);
    logic [7:0] r;
    if (LSB_FIRST) begin
      r = {1'b0, v[7:1]};
    end else begin
      r = {v[6:0], 1'b0};
    end
    return r;
  endfunction

  // Next-state and datapath update
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    div_s     = div_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = SCK_LO;
          shift_s   = data_in;
          bit_cnt_s = 4'd0;
          div_s     = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SCK_LO: begin
        if (div_r == DIV_LAST) begin
          div_s   = 8'd0;
          state_s = SCK_HI;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      SCK_HI: begin
        if (div_r == DIV_LAST) begin
          div_s     = 8'd0;
          shift_s   = shift_toward_head(shift_r);
          bit_cnt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_s == BIT_LAST) begin
            state_s = LATCH;
          end else begin
            state_s = SCK_LO;
          end
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      LATCH: begin
        if (div_r == DIV_LAST) begin
          div_s   = 8'd0;
          state_s = FIN;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so each pin comes straight from a flop.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    si_s   = 1'b0;
    sck_s  = 1'b0;
    rck_s  = 1'b0;
    case (state_s)
      SCK_LO: begin
        busy_s = 1'b1;
        si_s   = head_bit(shift_s);
      end
      SCK_HI: begin
        busy_s = 1'b1;
        sck_s  = 1'b1;
        si_s   = head_bit(shift_s);
      end
      LATCH: begin
        busy_s = 1'b1;
        rck_s  = 1'b1;
      end
      FIN: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      shift_r   <= 8'd0;
      bit_cnt_r <= 4'd0;
      div_r     <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      si        <= 1'b0;
      sck       <= 1'b0;
      rck       <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      div_r     <= div_s;
      busy      <= busy_s;
      done      <= done_s;
      si        <= si_s;
      sck       <= sck_s;
      rck       <= rck_s;
    end
  end

endmodule

// File: tb/tb_hc595_serial_loader.sv
// Bench for hc595_serial_loader: three instances (D=2 MSB-first, D=2 LSB-first, D=1 MSB-first)
// each feeding a behavioural 595 shift/latch model.
module tb_hc595_serial_loader;

  localparam int DIV_OF [3] = '{2, 2, 1};
  localparam bit LSB_OF [3] = '{1'b0, 1'b1, 1'b0};

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      start_v;
  logic [2:0][7:0] din_v;
  logic [2:0]      busy_v, done_v, si_v, sck_v, rck_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hc595_serial_loader #(.CLK_DIV(2), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .start(start_v[0]), .data_in(din_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .si(si_v[0]), .sck(sck_v[0]), .rck(rck_v[0]));

  hc595_serial_loader #(.CLK_DIV(2), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .start(start_v[1]), .data_in(din_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .si(si_v[1]), .sck(sck_v[1]), .rck(rck_v[1]));

  hc595_serial_loader #(.CLK_DIV(1), .LSB_FIRST(1'b0)) u_fast (
    .clk(clk), .rst(rst), .start(start_v[2]), .data_in(din_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .si(si_v[2]), .sck(sck_v[2]), .rck(rck_v[2]));

  // Downstream 595: shift si on each sck rise, copy to q on each rck rise.
  logic [2:0] sck_p = 3'b000;
  logic [2:0] rck_p = 3'b000;
  logic [7:0] sr_m [3];
  logic [7:0] q_m [3];
  int sck_rises [3] = '{0, 0, 0};
  int rck_rises [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (sck_v[g] && !sck_p[g]) begin
        sr_m[g]      <= {sr_m[g][6:0], si_v[g]};
        sck_rises[g] <= sck_rises[g] + 1;
      end
      if (rck_v[g] && !rck_p[g]) begin
        q_m[g]       <= sr_m[g];
        rck_rises[g] <= rck_rises[g] + 1;
      end
    end
    sck_p <= sck_v;
    rck_p <= rck_v;
  end

  // Order in which bits should appear on si, first bit in the MSB position.
  function automatic logic [7:0] ref_seq(input logic [7:0] d, input bit lsb);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[7-i] = lsb ? d[i] : d[7-i];
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    start_v = 3'b111;
    din_v = {3{8'hFF}};
    repeat (4) @(negedge clk);
    checks++; if (busy_v !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b want 000", busy_v); end
    checks++; if (done_v !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", done_v); end
    checks++; if (si_v !== 3'b000) begin errors++; $display("FAIL reset_si: got %b want 000", si_v); end
    checks++; if (sck_v !== 3'b000) begin errors++; $display("FAIL reset_sck: got %b want 000", sck_v); end
    checks++; if (rck_v !== 3'b000) begin errors++; $display("FAIL reset_rck: got %b want 000", rck_v); end
    start_v = 3'b000;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if ({busy_v, sck_v, rck_v, done_v} !== 12'd0) begin
      errors++; $display("FAIL reset_release_idle: got %b want 0", {busy_v, sck_v, rck_v, done_v});
    end
  endtask

  // One transfer on instance idx; inject_n>0 pulses a competing start (data FF) in that cycle.
  task automatic run_xfer(input int idx, input logic [7:0] data, input int inject_n, input string tag);
    int d, n, done_n, done_cnt, busy_cnt, rck_cnt, rck_first, sck_bad, si_bad, sr0, rr0;
    bit lsb;
    logic exp_sck, exp_si;
    logic [7:0] seq;
    d = DIV_OF[idx];
    lsb = LSB_OF[idx];
    seq = ref_seq(data, lsb);
    sr0 = sck_rises[idx];
    rr0 = rck_rises[idx];
    done_n = 0; done_cnt = 0; busy_cnt = 0; rck_cnt = 0; rck_first = 0; sck_bad = 0; si_bad = 0;
    din_v[idx] = data;
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_v[idx] = 1'b0;
    din_v[idx] = 8'($urandom);
    for (n = 1; n <= 17 * d + 6; n++) begin
      @(negedge clk);
      exp_sck = (n <= 16 * d) && ((((n - 1) / d) % 2) == 1);
      exp_si = (n <= 16 * d) ? seq[7 - ((n - 1) / (2 * d))] : 1'b0;
      if (sck_v[idx] !== exp_sck) sck_bad++;
      if (si_v[idx] !== exp_si) si_bad++;
      if (busy_v[idx] === 1'b1) busy_cnt++;
      if (rck_v[idx] === 1'b1) begin
        rck_cnt++;
        if (rck_first == 0) rck_first = n;
      end
      if (done_v[idx] === 1'b1) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (n == inject_n) begin
        start_v[idx] = 1'b1;
        din_v[idx] = 8'hFF;
      end else begin
        start_v[idx] = 1'b0;
      end
    end
    start_v[idx] = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (done_n != 17 * d + 1) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_n, 17 * d + 1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", tag, done_cnt); end
    checks++; if (busy_cnt != 17 * d) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, 17 * d); end
    checks++; if (rck_first != 16 * d + 1) begin errors++; $display("FAIL %s rck_start: got %0d want %0d", tag, rck_first, 16 * d + 1); end
    checks++; if (rck_cnt != d) begin errors++; $display("FAIL %s rck_width: got %0d want %0d", tag, rck_cnt, d); end
    checks++; if (sck_bad != 0) begin errors++; $display("FAIL %s sck_timing: got %0d bad cycles want 0", tag, sck_bad); end
    checks++; if (si_bad != 0) begin errors++; $display("FAIL %s si_timing: got %0d bad cycles want 0", tag, si_bad); end
    checks++; if (sck_rises[idx] - sr0 != 8) begin errors++; $display("FAIL %s sck_edges: got %0d want 8", tag, sck_rises[idx] - sr0); end
    checks++; if (rck_rises[idx] - rr0 != 1) begin errors++; $display("FAIL %s rck_pulses: got %0d want 1", tag, rck_rises[idx] - rr0); end
    checks++; if (sr_m[idx] !== seq) begin errors++; $display("FAIL %s si_sequence: got %h want %h", tag, sr_m[idx], seq); end
    checks++; if (q_m[idx] !== seq) begin errors++; $display("FAIL %s latched_q: got %h want %h", tag, q_m[idx], seq); end
    checks++; if (busy_v[idx] !== 1'b0) begin errors++; $display("FAIL %s idle_after: got busy=%b want 0", tag, busy_v[idx]); end
  endtask

  task automatic test_reset_mid();
    int rr0, rck_seen, done_seen;
    rr0 = rck_rises[0];
    rck_seen = 0;
    done_seen = 0;
    din_v[0] = 8'hF0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (19) @(negedge clk);
    checks++; if (sck_v[0] !== 1'b1) begin errors++; $display("FAIL mid_bit4_sck: got %b want 1", sck_v[0]); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({busy_v[0], sck_v[0], rck_v[0], si_v[0]} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_async: got %b want 0000", {busy_v[0], sck_v[0], rck_v[0], si_v[0]});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rck_v[0] === 1'b1) rck_seen++;
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) done_seen++;
    end
    checks++; if (rck_seen != 0 || rck_rises[0] != rr0) begin
      errors++; $display("FAIL mid_no_rck: got %0d high cycles want 0", rck_seen);
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL mid_stays_idle: got %0d active cycles want 0", done_seen); end
    run_xfer(0, 8'h0F, 0, "after_reset_0f");
  endtask

  task automatic test_back_to_back();
    logic [7:0] hist [64];
    int next_acc, nd;
    next_acc = 0;
    nd = 0;
    hist[0] = 8'($urandom);
    din_v[2] = hist[0];
    start_v[2] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done_v[2] === 1'b1) begin
        checks++; if (n != next_acc + 18) begin errors++; $display("FAIL b2b_done_cycle: got %0d want %0d", n, next_acc + 18); end
        checks++; if (q_m[2] !== hist[next_acc]) begin errors++; $display("FAIL b2b_latched: got %h want %h", q_m[2], hist[next_acc]); end
        next_acc = next_acc + 19;
        nd++;
      end
      if (n == 56) start_v[2] = 1'b0;
      hist[n] = 8'($urandom);
      din_v[2] = hist[n];
    end
    checks++; if (nd != 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
    checks++; if (busy_v[2] !== 1'b0) begin errors++; $display("FAIL b2b_idle_end: got %b want 0", busy_v[2]); end
  endtask

  task automatic test_random();
    int idx;
    for (int i = 0; i < 6; i++) begin
      idx = int'($urandom_range(0, 2));
      run_xfer(idx, 8'($urandom), 0, "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    start_v = 3'b000;
    din_v = '0;
    #2;
    test_reset();
    run_xfer(0, 8'hA5, 0, "basic_a5");
    run_xfer(1, 8'h01, 0, "lsb_01");
    run_xfer(0, 8'h3C, 10, "ignored_3c");
    run_xfer(0, 8'hC3, 0, "after_done_c3");
    run_xfer(1, 8'h5A, 35, "start_in_fin");
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hc595_serial_loader.md
# hc595_serial_loader

Upstream driver for the 74HC595-style shift/latch stage. It accepts a parallel byte with a one-cycle start request and serializes it onto the stage's SI/SCK inputs. After the last bit it issues a single RCK pulse, so the byte appears on the stage's storage outputs without manual button presses. It sits between any byte source (switch bank, counter, test pattern) and the shift/latch stage that feeds the seven-segment decoders.

## Interface
- CLK_DIV, 4: half-period of SCK in clk cycles; also the RCK high width; legal range 1..255.
- LSB_FIRST, 0: 0 = shift data_in[7] first, 1 = shift data_in[0] first.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- start  input  1  load request, sampled each clk; accepted only when busy=0.
- data_in  input  8  byte to transmit, captured on the accepting edge.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  single-cycle pulse when the transfer, including RCK, is complete.
- si  output  1  serial data to the stage's SI input.
- sck  output  1  shift clock to the stage's SCK input; data is taken on its rising edge.
- rck  output  1  latch clock to the stage's RCK input.

## Operation
- All outputs are registered. The reset value of busy, done, si, sck and rck is 0. The internal shift register, bit counter and divider counter also reset to 0.
- FSM states: IDLE, SCK_LO, SCK_HI, LATCH, FIN.
- IDLE:
  - If start=1, capture data_in into the 8-bit shift register, clear the bit counter and divider, and go to SCK_LO.
  - Otherwise stay in IDLE.
- SCK_LO:
  - sck=0; si = current head bit (MSB, or LSB when LSB_FIRST=1).
  - After CLK_DIV cycles, go to SCK_HI.
- SCK_HI:
  - sck=1; si is held unchanged.
  - After CLK_DIV cycles, shift the register by one (toward the head) and increment the bit counter.
  - Go to LATCH if the counter reaches 8, else go to SCK_LO.
- LATCH:
  - sck=0, si=0, rck=1 for CLK_DIV cycles, then go to FIN.
- FIN:
  - rck=0, done=1, busy=0 for one cycle, then go to IDLE.
- start while busy=1 (any non-IDLE state, including FIN) is ignored and not queued. data_in changes after acceptance have no effect.
- start held high continuously triggers back-to-back transfers. Each new transfer is accepted in the first IDLE cycle after FIN.
- Reset asserted mid-transfer: the FSM returns to IDLE and all outputs drop to 0 asynchronously. No partial RCK pulse is issued after reset is released.
- Counter widths: the divider counter is 8 bits and the bit counter is 4 bits; neither wraps within a legal transfer.

## Timing
- Let edge k be the clk edge where start is accepted, and let D = CLK_DIV.
- busy rises after edge k.
- Bit i (i=0..7, i=0 is the head bit):
  - sck is low for clk cycles k+1+2iD .. k+2iD+D.
  - sck is high for cycles k+1+2iD+D .. k+2(i+1)D.
  - si is stable over both phases, so it has D cycles of setup before the SCK rising edge and D cycles of hold after it.
- rck is high for cycles k+1+16D .. k+17D.
- done=1 and busy=0 in cycle k+17D+1.
- The earliest next acceptance is edge k+17D+2.
- Total latency from acceptance to done: 17D+1 cycles.
- No glitches on sck or rck: each changes at most once per state change, from flops only.

## Test plan
- Reset: hold rst=0 with start=1 and data_in=8'hFF -> busy, done, si, sck and rck all stay 0. Releasing rst with start=0 -> FSM stays IDLE.
- Basic transfer, CLK_DIV=2, LSB_FIRST=0, data_in=8'hA5 for one cycle:
  - si sampled at the 8 sck rising edges is 1,0,1,0,0,1,0,1.
  - rck is high for exactly 2 cycles, after the 8th sck falling edge.
  - done pulses at cycle k+35; busy is high for 34 cycles.
  - A behavioural 595 model connected downstream shows q=8'hA5.
- LSB_FIRST=1, data_in=8'h01 -> first sampled si is 1 and the remaining seven are 0. The downstream model shows q=8'h80.
- Ignored start: pulse start with 8'h3C, then again mid-transfer with 8'hFF -> only one done, and the latched value is 8'h3C. A third start after done with 8'hC3 latches 8'hC3.
- Reset mid-operation: assert rst during bit 4 of 8'hF0 -> sck, rck, si and busy are 0 immediately, no rck pulse occurs, and the next transfer of 8'h0F completes correctly.
- Continuous start=1 with CLK_DIV=1 -> consecutive done pulses are 19 cycles apart, and each transfer latches the data_in value present at its accepting edge.
